keyboard: RTL and testbench

//   Scanner for a 4x4 matrix keypad. Drives one column low at a time and samples the active-low rows.

---
 rtl/keyboard.sv | 203 ++++++++++++++++++++
 tb/tb_keyboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard.sv
// Purpose: 4x4 active-low matrix keypad scanner with sweep-level debounce and a one-shot valid/ready press event.
// Latency: press to key_valid is at most (DEBOUNCE_SWEEPS+1)*4 scan ticks plus 3 clk cycles.
// Backpressure: key_valid/pressed_index hold until key_valid && key_ready; presses that stabilise meanwhile are dropped.
// Optional build macro KEYBOARD_GHOST_REJECT_EN: a sweep with more than one key down counts as "no key".
module keyboard #(
  parameter int DEBOUNCE_SWEEPS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_clk,
  input  logic       en,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] pressed_index
);

  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SWEEPS);

  // scan_clk synchronizer and edge-detect history
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync3_q, sync3_d;
  // column drive
  logic [1:0] col_q, col_d;
  logic [3:0] col_drv_q, col_drv_d;
  // per-sweep accumulator
  logic       acc_vld_q, acc_vld_d;
  logic [3:0] acc_idx_q, acc_idx_d;
  // debounce history
  logic          prev_vld_q, prev_vld_d;
  logic [3:0]    prev_idx_q, prev_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // event control
  logic       armed_q, armed_d;
  logic       skip_q, skip_d;
  logic       key_valid_q, key_valid_d;
  logic [3:0] pressed_index_q, pressed_index_d;

  logic       scan_tick;
  logic       row_hit;
  logic [1:0] row_num;
  logic [3:0] samp_idx;
  logic       merged_vld;
  logic [3:0] merged_idx;
  logic       sweep_vld;
  logic       sweep_same;
`ifdef KEYBOARD_GHOST_REJECT_EN
  logic       acc_multi_q, acc_multi_d;
  logic       row_multi;
  logic       merged_multi;
`endif

  assign scan_tick     = sync2_q & ~sync3_q;
  assign keyboard_col  = col_drv_q;
  assign key_valid     = key_valid_q;
  assign pressed_index = pressed_index_q;

  // Decode the sampled row code and merge it into this sweep's lowest-index result
  always_comb begin
    row_hit = 1'b1;
    row_num = 2'd0;
    if (!keyboard_row[3])      row_num = 2'd0;
    else if (!keyboard_row[2]) row_num = 2'd1;
    else if (!keyboard_row[1]) row_num = 2'd2;
    else if (!keyboard_row[0]) row_num = 2'd3;
    else                       row_hit = 1'b0;
    samp_idx   = {row_num, col_q};
    merged_vld = acc_vld_q | row_hit;
    merged_idx = acc_idx_q;
    if (row_hit && (!acc_vld_q || (samp_idx < acc_idx_q))) merged_idx = samp_idx;
`ifdef KEYBOARD_GHOST_REJECT_EN
    // two rows in one column, or hits in two different columns
    row_multi    = ($countones(~keyboard_row) > 1);
    merged_multi = acc_multi_q | row_multi | (row_hit & acc_vld_q);
    sweep_vld    = merged_vld & ~merged_multi;
`else
    sweep_vld    = merged_vld;
`endif
    sweep_same = (sweep_vld == prev_vld_q) && (!sweep_vld || (merged_idx == prev_idx_q));
  end

  // Next-state: scan advance, sweep debounce, press event and handshake
  always_comb begin
    sync1_d         = scan_clk;
    sync2_d         = sync1_q;
    sync3_d         = sync2_q;
    col_d           = col_q;
    acc_vld_d       = acc_vld_q;
    acc_idx_d       = acc_idx_q;
    prev_vld_d      = prev_vld_q;
    prev_idx_d      = prev_idx_q;
    cnt_d           = cnt_q;
    armed_d         = armed_q;
    skip_d          = skip_q;
    key_valid_d     = key_valid_q;
    pressed_index_d = pressed_index_q;
`ifdef KEYBOARD_GHOST_REJECT_EN
    acc_multi_d     = acc_multi_q;
`endif

    if (key_valid_q && key_ready) key_valid_d = 1'b0;

    if (!en) begin
      key_valid_d = 1'b0;
      acc_vld_d   = 1'b0;
      acc_idx_d   = 4'd0;
      prev_vld_d  = 1'b0;
      prev_idx_d  = 4'd0;
      cnt_d       = '0;
      armed_d     = 1'b1;
`ifdef KEYBOARD_GHOST_REJECT_EN
      acc_multi_d = 1'b0;
`endif
      // column counter holds, so the first sweep after re-enable may be partial
      if (col_q != 2'd0) skip_d = 1'b1;
    end else if (scan_tick) begin
      col_d = col_q + 2'd1;
      if (col_q != 2'd3) begin
        acc_vld_d   = merged_vld;
        acc_idx_d   = merged_idx;
`ifdef KEYBOARD_GHOST_REJECT_EN
        acc_multi_d = merged_multi;
`endif
      end else begin
        acc_vld_d   = 1'b0;
        acc_idx_d   = 4'd0;
`ifdef KEYBOARD_GHOST_REJECT_EN
        acc_multi_d = 1'b0;
`endif
        if (skip_q) begin
          skip_d = 1'b0;
        end else begin
          if (!sweep_same)          cnt_d = CW'(1);
          else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          prev_vld_d = sweep_vld;
          prev_idx_d = merged_idx;
          if (cnt_d == CNT_MAX) begin
            if (!sweep_vld) begin
              armed_d = 1'b1;
            end else if (armed_q) begin
              armed_d = 1'b0;
              // a press that stabilises while an event is pending is dropped
              if (!key_valid_q) begin
                key_valid_d     = 1'b1;
                pressed_index_d = merged_idx;
              end
            end
          end
        end
      end
    end
  end

  // Column drive tracks the next column so it is settled before the next tick samples it
  always_comb begin
    col_drv_d = en ? ~(4'b1000 >> col_d) : 4'b1111;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      sync3_q         <= 1'b0;
      col_q           <= 2'd0;
      col_drv_q       <= 4'b1111;
      acc_vld_q       <= 1'b0;
      acc_idx_q       <= 4'd0;
      prev_vld_q      <= 1'b0;
      prev_idx_q      <= 4'd0;
      cnt_q           <= '0;
      armed_q         <= 1'b1;
      skip_q          <= 1'b0;
      key_valid_q     <= 1'b0;
      pressed_index_q <= 4'd0;
`ifdef KEYBOARD_GHOST_REJECT_EN
      acc_multi_q     <= 1'b0;
`endif
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      sync3_q         <= sync3_d;
      col_q           <= col_d;
      col_drv_q       <= col_drv_d;
      acc_vld_q       <= acc_vld_d;
      acc_idx_q       <= acc_idx_d;
      prev_vld_q      <= prev_vld_d;
      prev_idx_q      <= prev_idx_d;
      cnt_q           <= cnt_d;
      armed_q         <= armed_d;
      skip_q          <= skip_d;
      key_valid_q     <= key_valid_d;
      pressed_index_q <= pressed_index_d;
`ifdef KEYBOARD_GHOST_REJECT_EN
      acc_multi_q     <= acc_multi_d;
`endif
    end
  end

endmodule

// File: tb/tb_keyboard.sv
// Bench for keyboard: a keypad matrix model driven from a 16-bit "keys held" vector,
// a table of press scenarios, then hand-written backpressure, enable and reset sequences.
module tb_keyboard;

  localparam int TICK_CYC = 20;                    // clk cycles per scan_clk period ("1 ms")
  localparam int LAT_MAX  = 16 * TICK_CYC + 3;     // press-to-valid bound in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  keyboard_row;
  logic [3:0]  keyboard_col;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic [3:0]  pressed_index;
  logic [15:0] keys = 16'h0;

  int total = 0;
  int bad   = 0;

  keyboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_clk     (scan_clk),
    .en           (en),
    .keyboard_row (keyboard_row),
    .keyboard_col (keyboard_col),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .pressed_index(pressed_index)
  );

  always #5 clk = ~clk;
  always #(TICK_CYC * 5) scan_clk = ~scan_clk;

  // Keypad matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    keyboard_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keyboard_col[3-c]) keyboard_row[3-r] = 1'b0;
  end

  typedef struct {
    logic        en;
    logic [15:0] keys;
    int          hold;      // ticks
    int          gap;       // ticks
    int          ready_dly; // clk cycles from valid to ready
    bit          exp_ev;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int         events;
    int         lat;
    logic [3:0] got;
    bit         col_ok;
    bit         stable;
    bit         late_ev;
    events = 0; lat = -1; got = 4'hx; col_ok = 1'b1; stable = 1'b1; late_ev = 1'b0;
    key_ready = 1'b0;
    en   = v.en;
    keys = v.keys;
    for (int i = 0; i < v.hold * TICK_CYC; i++) begin
      @(negedge clk);
      if (!v.en && keyboard_col !== 4'hF) col_ok = 1'b0;
      if (key_valid === 1'b1) begin
        if (events == 0) begin lat = i; got = pressed_index; end
        events++;
        for (int d = 0; d < v.ready_dly; d++) begin
          @(negedge clk); i++;
          if (key_valid !== 1'b1 || pressed_index !== got) stable = 1'b0;
        end
        // ready stays high afterwards: it must be ignored while key_valid=0
        key_ready = 1'b1;
        @(negedge clk); i++;
        chk($sformatf("v%0d_drop", n), key_valid, 1'b0);
      end
    end
    keys = 16'h0;
    for (int i = 0; i < v.gap * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) late_ev = 1'b1;
    end
    key_ready = 1'b0;
    chk($sformatf("v%0d_events", n), events, v.exp_ev ? 1 : 0);
    chk($sformatf("v%0d_gap_quiet", n), late_ev, 1'b0);
    if (v.exp_ev) begin
      chk($sformatf("v%0d_index", n), got, v.exp_idx);
      chk($sformatf("v%0d_latency_ok", n), (lat >= 0 && lat <= LAT_MAX), 1'b1);
      chk($sformatf("v%0d_held_stable", n), stable, 1'b1);
    end
    if (!v.en) chk($sformatf("v%0d_col_idle", n), col_ok, 1'b1);
  endtask

  initial begin
    bit seen;
    bit stable;
    bit quiet;

    // vector table
    vecs[0] = '{1'b0, 16'h0002, 35, 5, 3, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 16'h0020, 40, 5, 3, 1'b0, 4'h0};
    vecs[2] = '{1'b0, 16'h0400, 45, 5, 3, 1'b0, 4'h0};
    vecs[3] = '{1'b1, 16'h4000, 75, 20, 10, 1'b1, 4'hE};
    for (int k = 0; k < 16; k++)
      vecs[4+k] = '{1'b1, 16'h0001 << k, 22 + (k % 4), 20, 3, 1'b1, 4'(k)};
`ifdef KEYBOARD_GHOST_REJECT_EN
    vecs[20] = '{1'b1, 16'h0204, 30, 20, 3, 1'b0, 4'h2};
`else
    vecs[20] = '{1'b1, 16'h0204, 30, 20, 3, 1'b1, 4'h2};
`endif

    // reset state
    repeat (5) @(negedge clk);
    chk("reset_col", keyboard_col, 4'hF);
    chk("reset_valid", key_valid, 1'b0);
    chk("reset_index", pressed_index, 4'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int n = 0; n < 21; n++) begin
      if (n == 3) begin
        en = 1'b1;
        repeat (10 * TICK_CYC) @(negedge clk);
      end
      run_vec(vecs[n], n);
    end

    // backpressure: F held without ready, then 3 pressed while F still pending
    keys = 16'h8000;
    wait_valid(20 * TICK_CYC, seen);
    chk("bp_f_seen", seen, 1'b1);
    chk("bp_f_index", pressed_index, 4'hF);
    stable = 1'b1;
    for (int i = 0; i < 15 * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b1 || pressed_index !== 4'hF) stable = 1'b0;
    end
    keys = 16'h0;
    for (int i = 0; i < 20 * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b1 || pressed_index !== 4'hF) stable = 1'b0;
    end
    keys = 16'h0008;
    for (int i = 0; i < 25 * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b1 || pressed_index !== 4'hF) stable = 1'b0;
    end
    chk("bp_f_held_stable", stable, 1'b1);
    key_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_drop", key_valid, 1'b0);
    key_ready = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20 * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b0) quiet = 1'b0;
    end
    chk("bp_3_dropped", quiet, 1'b1);
    keys = 16'h0;
    repeat (20 * TICK_CYC) @(negedge clk);

    // deasserting en clears a pending event; presses while disabled are ignored
    keys = 16'h0080;
    wait_valid(20 * TICK_CYC, seen);
    chk("en_7_seen", seen, 1'b1);
    chk("en_7_index", pressed_index, 4'h7);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_valid", key_valid, 1'b0);
    chk("en_off_col", keyboard_col, 4'hF);
    quiet = 1'b1;
    for (int i = 0; i < 20 * TICK_CYC; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b0) quiet = 1'b0;
    end
    chk("en_off_quiet", quiet, 1'b1);
    keys = 16'h0;
    en = 1'b1;
    repeat (10 * TICK_CYC) @(negedge clk);

    // reset while an event is pending
    keys = 16'h0010;
    wait_valid(20 * TICK_CYC, seen);
    chk("rst_4_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", key_valid, 1'b0);
    chk("rst_mid_index", pressed_index, 4'h0);
    chk("rst_mid_col", keyboard_col, 4'hF);
    keys = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
